router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
- Datapath register stage of the 1x3 router, directly downstream of the router control FSM.
- Consumes the FSM state decodes and drives the byte presented to the destination FIFOs (dout).
- Latches the header, parks one byte while the FIFO is full, and accumulates running parity.
- Reports parity_done, low_pkt_valid and err back to the FSM and the top level.

Parameters:
WIDTH, 8, byte width of data_in/dout/parity registers (must be >= 3; bits [1:0] are the destination address)

Ports:
clock  input  1  rising-edge clock
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  source drives packet byte; deasserts on the cycle the parity byte is on data_in
data_in  input  WIDTH  source byte: header ([WIDTH-1:2] length, [1:0] addr), payload, then parity
fifo_full  input  1  full flag of the currently addressed FIFO
detect_add  input  1  FSM in DECODE_ADDRESS
lfd_state  input  1  FSM in LOAD_FIRST_DATA
ld_state  input  1  FSM in LOAD_DATA
laf_state  input  1  FSM in LOAD_AFTER_FULL
full_state  input  1  FSM in FIFO_FULL_STATE
rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR
dout  output  WIDTH  byte written to the addressed FIFO
parity_done  output  1  parity byte has been forwarded to dout
low_pkt_valid  output  1  pkt_valid fell while in LOAD_DATA
err  output  1  received parity != computed parity

Behaviour:
- All outputs and internal registers (header_byte, hold_byte, internal_parity, packet_parity) are registered and clear to 0 when resetn=0 at a clock edge. Reset mid-packet discards everything. No soft-reset input; the FSM handles soft reset.
- State inputs are one-hot or all zero. Behaviour is undefined if more than one is asserted.
- Header capture: when detect_add=1, pkt_valid=1 and data_in[1:0]!=2'b11, set header_byte<=data_in. dout holds. Address 2'b11 is ignored.
- dout update priority:
  - lfd_state: dout<=header_byte.
  - ld_state & ~fifo_full: dout<=data_in.
  - ld_state & fifo_full: hold_byte<=data_in; dout holds.
  - laf_state: dout<=hold_byte.
  - Otherwise, including full_state: dout holds.
- Latency: a byte on data_in in LOAD_DATA appears on dout 1 cycle later, aligned with the FSM's write enable on the following cycle.
- internal_parity:
  - detect_add: cleared to 0.
  - lfd_state: ^= header_byte.
  - ld_state & pkt_valid & ~full_state: ^= data_in. This includes a byte diverted to hold_byte, and it is counted exactly once.
- packet_parity: cleared on detect_add. Loaded with data_in on ld_state & ~pkt_valid, irrespective of fifo_full.
- low_pkt_valid:
  - Set on ld_state & ~pkt_valid.
  - Cleared on rst_int_reg.
  - Set takes priority if both occur in the same cycle, which cannot happen in legal FSM operation.
- parity_done:
  - Cleared on detect_add.
  - Set on (ld_state & ~fifo_full & ~pkt_valid), i.e. the parity byte goes straight to dout.
  - Set on (laf_state & low_pkt_valid & ~parity_done), i.e. the parity byte was parked in hold_byte.
  - Once set, it holds until the next detect_add.
- err:
  - Cleared on detect_add.
  - Set to 1 on rst_int_reg & parity_done & (internal_parity != packet_parity).
  - Otherwise holds, so it stays visible from CHECK_PARITY_ERROR until the next packet's DECODE_ADDRESS.
- Boundary cases:
  - fifo_full rising on the parity cycle: the parity byte goes to hold_byte, and parity_done is set in LOAD_AFTER_FULL.
  - fifo_full during lfd_state: the header is still driven to dout; the FSM guarantees write ordering.
  - Zero-length payload: parity = header_byte.
- Expected size: 120-200 lines RTL, one always block per register group.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with random inputs -> dout=0, parity_done=0, low_pkt_valid=0, err=0.
- Good packet: header 8'h0D (len 3, addr 1), payload 11/22/33, parity 8'h0D, no full -> dout sequence 0D,11,22,33,0D one cycle after each state; parity_done=1 the cycle after the parity byte; err=0 during rst_int_reg.
- Bad parity: same packet with parity byte 8'h00 -> err=1 the cycle after rst_int_reg; err clears to 0 on the next detect_add.
- FIFO full mid-payload: fifo_full=1 while ld_state with data 8'h22 -> dout holds 8'h11. full_state cycles -> dout holds. laf_state -> dout=8'h22. Final parity still matches, err=0.
- Full on parity byte: fifo_full=1 when pkt_valid drops with parity 8'h0D -> parity_done stays 0, low_pkt_valid=1. After laf_state -> dout=8'h0D, parity_done=1, err=0.
- Header address 2'b11 (8'h07) with detect_add -> header_byte unchanged. Reset asserted mid-payload -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
//
// Sits directly downstream of the router control FSM and uses its one-hot
// state decodes to steer the byte presented to the destination FIFOs.
// It latches the packet header, parks one byte while the addressed FIFO is
// full, accumulates running parity and flags a parity mismatch.
//
// Ports:
//   clock          rising-edge clock
//   resetn         synchronous active-low reset
//   pkt_valid      source byte valid; drops on the parity byte
//   data_in        header ([WIDTH-1:2] length, [1:0] addr), payload, parity
//   fifo_full      full flag of the currently addressed FIFO
//   detect_add     FSM in DECODE_ADDRESS
//   lfd_state      FSM in LOAD_FIRST_DATA
//   ld_state       FSM in LOAD_DATA
//   laf_state      FSM in LOAD_AFTER_FULL
//   full_state     FSM in FIFO_FULL_STATE
//   rst_int_reg    FSM in CHECK_PARITY_ERROR
//   dout           byte written to the addressed FIFO
//   parity_done    parity byte has been forwarded to dout
//   low_pkt_valid  pkt_valid fell while in LOAD_DATA
//   err            received parity differs from computed parity
module router_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fifo_full,
  input  logic             detect_add,
  input  logic             lfd_state,
  input  logic             ld_state,
  input  logic             laf_state,
  input  logic             full_state,
  input  logic             rst_int_reg,
  output logic [WIDTH-1:0] dout,
  output logic             parity_done,
  output logic             low_pkt_valid,
  output logic             err
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] header_byte_q, header_byte_d;
  logic [WIDTH-1:0] hold_byte_q, hold_byte_d;
  logic [WIDTH-1:0] internal_parity_q, internal_parity_d;
  logic [WIDTH-1:0] packet_parity_q, packet_parity_d;
  logic             parity_done_q, parity_done_d;
  logic             low_pkt_valid_q, low_pkt_valid_d;
  logic             err_q, err_d;

  // Header and dout/hold steering.
  always_comb begin
    header_byte_d = header_byte_q;
    hold_byte_d   = hold_byte_q;
    dout_d        = dout_q;

    // Address 2'b11 has no destination FIFO, so such a header is ignored.
    if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
      header_byte_d = data_in;
    end

    if (lfd_state) begin
      dout_d = header_byte_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (ld_state && fifo_full) begin
      // Park the byte; it is replayed from hold_byte in LOAD_AFTER_FULL.
      hold_byte_d = data_in;
    end else if (laf_state) begin
      dout_d = hold_byte_q;
    end
  end

  // Parity accumulation and status flags.
  always_comb begin
    internal_parity_d = internal_parity_q;
    packet_parity_d   = packet_parity_q;
    low_pkt_valid_d   = low_pkt_valid_q;
    parity_done_d     = parity_done_q;
    err_d             = err_q;

    // A parked byte is folded in when it arrives, never again on replay.
    if (detect_add) begin
      internal_parity_d = '0;
    end else if (lfd_state) begin
      internal_parity_d = internal_parity_q ^ header_byte_q;
    end else if (ld_state && pkt_valid && !full_state) begin
      internal_parity_d = internal_parity_q ^ data_in;
    end

    if (detect_add) begin
      packet_parity_d = '0;
    end else if (ld_state && !pkt_valid) begin
      packet_parity_d = data_in;
    end

    // Set wins over clear.
    if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end else if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end

    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (ld_state && !fifo_full && !pkt_valid) begin
      parity_done_d = 1'b1;
    end else if (laf_state && low_pkt_valid_q && !parity_done_q) begin
      // Parity byte was parked and is being replayed now.
      parity_done_d = 1'b1;
    end

    if (detect_add) begin
      err_d = 1'b0;
    end else if (rst_int_reg && parity_done_q && (internal_parity_q != packet_parity_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout_q        <= '0;
      header_byte_q <= '0;
      hold_byte_q   <= '0;
    end else begin
      dout_q        <= dout_d;
      header_byte_q <= header_byte_d;
      hold_byte_q   <= hold_byte_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      internal_parity_q <= '0;
      packet_parity_q   <= '0;
    end else begin
      internal_parity_q <= internal_parity_d;
      packet_parity_q   <= packet_parity_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      low_pkt_valid_q <= 1'b0;
      parity_done_q   <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_done_q   <= parity_done_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
module tb_router_reg;

  localparam int StNone = 0;
  localparam int StDa   = 1;
  localparam int StLfd  = 2;
  localparam int StLd   = 3;
  localparam int StLaf  = 4;
  localparam int StFull = 5;
  localparam int StRir  = 6;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  router_reg #(.WIDTH(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_state(input int st);
    detect_add  = (st == StDa);
    lfd_state   = (st == StLfd);
    ld_state    = (st == StLd);
    laf_state   = (st == StLaf);
    full_state  = (st == StFull);
    rst_int_reg = (st == StRir);
  endtask

  // Drive one cycle, push the expected post-edge outputs, then pop and compare.
  task automatic cyc(input string tag, input int st, input logic pv, input logic [7:0] din,
                     input logic ff, input logic [7:0] e_dout, input logic e_pd,
                     input logic e_lpv, input logic e_err);
    exp_t e;
    set_state(st);
    pkt_valid = pv;
    data_in   = din;
    fifo_full = ff;
    e.tag = tag; e.dout = e_dout; e.pd = e_pd; e.lpv = e_lpv; e.err = e_err;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, ".dout"}, {24'h0, dout}, {24'h0, e.dout});
    check({e.tag, ".parity_done"}, {31'h0, parity_done}, {31'h0, e.pd});
    check({e.tag, ".low_pkt_valid"}, {31'h0, low_pkt_valid}, {31'h0, e.lpv});
    check({e.tag, ".err"}, {31'h0, err}, {31'h0, e.err});
  endtask

  initial begin
    resetn = 1'b0;
    set_state(StNone);
    pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
    #2;

    // Reset with random stimulus on every input.
    for (int i = 0; i < 2; i++) begin
      pkt_valid   = 1'($urandom);
      data_in     = 8'($urandom);
      fifo_full   = 1'($urandom);
      detect_add  = 1'($urandom);
      lfd_state   = 1'($urandom);
      ld_state    = 1'($urandom);
      laf_state   = 1'($urandom);
      full_state  = 1'($urandom);
      rst_int_reg = 1'($urandom);
      sb.push_back('{tag: "reset", dout: 8'h00, pd: 1'b0, lpv: 1'b0, err: 1'b0});
      @(posedge clock);
      #1;
      begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".dout"}, {24'h0, dout}, {24'h0, e.dout});
        check({e.tag, ".parity_done"}, {31'h0, parity_done}, {31'h0, e.pd});
        check({e.tag, ".low_pkt_valid"}, {31'h0, low_pkt_valid}, {31'h0, e.lpv});
        check({e.tag, ".err"}, {31'h0, err}, {31'h0, e.err});
      end
    end
    resetn = 1'b1;

    // Good packet: 0D, 11, 22, 33, parity 0D.
    cyc("good_da",  StDa,   1, 8'h0D, 0, 8'h00, 0, 0, 0);
    cyc("good_lfd", StLfd,  1, 8'h11, 0, 8'h0D, 0, 0, 0);
    cyc("good_ld1", StLd,   1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc("good_ld2", StLd,   1, 8'h22, 0, 8'h22, 0, 0, 0);
    cyc("good_ld3", StLd,   1, 8'h33, 0, 8'h33, 0, 0, 0);
    cyc("good_par", StLd,   0, 8'h0D, 0, 8'h0D, 1, 1, 0);
    cyc("good_rir", StRir,  0, 8'h00, 0, 8'h0D, 1, 0, 0);
    cyc("good_idl", StNone, 0, 8'h00, 0, 8'h0D, 1, 0, 0);

    // Bad parity: same packet with parity byte 00.
    cyc("bad_da",   StDa,   1, 8'h0D, 0, 8'h0D, 0, 0, 0);
    cyc("bad_lfd",  StLfd,  1, 8'h11, 0, 8'h0D, 0, 0, 0);
    cyc("bad_ld1",  StLd,   1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc("bad_ld2",  StLd,   1, 8'h22, 0, 8'h22, 0, 0, 0);
    cyc("bad_ld3",  StLd,   1, 8'h33, 0, 8'h33, 0, 0, 0);
    cyc("bad_par",  StLd,   0, 8'h00, 0, 8'h00, 1, 1, 0);
    cyc("bad_rir",  StRir,  0, 8'h00, 0, 8'h00, 1, 0, 1);
    cyc("bad_hold", StNone, 0, 8'h00, 0, 8'h00, 1, 0, 1);

    // FIFO full mid-payload; this detect_add also clears err.
    cyc("mid_da",   StDa,   1, 8'h0D, 0, 8'h00, 0, 0, 0);
    cyc("mid_lfd",  StLfd,  1, 8'h11, 0, 8'h0D, 0, 0, 0);
    cyc("mid_ld1",  StLd,   1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc("mid_ldf",  StLd,   1, 8'h22, 1, 8'h11, 0, 0, 0);
    cyc("mid_ful1", StFull, 1, 8'h22, 1, 8'h11, 0, 0, 0);
    cyc("mid_ful2", StFull, 1, 8'h22, 0, 8'h11, 0, 0, 0);
    cyc("mid_laf",  StLaf,  1, 8'h22, 0, 8'h22, 0, 0, 0);
    cyc("mid_ld3",  StLd,   1, 8'h33, 0, 8'h33, 0, 0, 0);
    cyc("mid_par",  StLd,   0, 8'h0D, 0, 8'h0D, 1, 1, 0);
    cyc("mid_rir",  StRir,  0, 8'h00, 0, 8'h0D, 1, 0, 0);

    // FIFO goes full on the parity byte.
    cyc("pf_da",    StDa,   1, 8'h0D, 0, 8'h0D, 0, 0, 0);
    cyc("pf_lfd",   StLfd,  1, 8'h11, 0, 8'h0D, 0, 0, 0);
    cyc("pf_ld1",   StLd,   1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc("pf_ld2",   StLd,   1, 8'h22, 0, 8'h22, 0, 0, 0);
    cyc("pf_ld3",   StLd,   1, 8'h33, 0, 8'h33, 0, 0, 0);
    cyc("pf_par",   StLd,   0, 8'h0D, 1, 8'h33, 0, 1, 0);
    cyc("pf_full",  StFull, 0, 8'h00, 1, 8'h33, 0, 1, 0);
    cyc("pf_laf",   StLaf,  0, 8'h00, 0, 8'h0D, 1, 1, 0);
    cyc("pf_rir",   StRir,  0, 8'h00, 0, 8'h0D, 1, 0, 0);

    // Address 2'b11 and invalid headers are ignored; header stays 0D.
    cyc("a3_da",    StDa,   1, 8'h07, 0, 8'h0D, 0, 0, 0);
    cyc("nv_da",    StDa,   0, 8'h16, 0, 8'h0D, 0, 0, 0);
    cyc("a3_lfd",   StLfd,  1, 8'h11, 0, 8'h0D, 0, 0, 0);
    cyc("a3_ld1",   StLd,   1, 8'h11, 0, 8'h11, 0, 0, 0);

    // Reset mid-payload, then prove the internal registers were cleared too.
    resetn = 1'b0;
    cyc("mrst",     StLd,   1, 8'h22, 0, 8'h00, 0, 0, 0);
    resetn = 1'b1;
    cyc("post_lfd", StLfd,  1, 8'h55, 0, 8'h00, 0, 0, 0);
    cyc("post_par", StLd,   0, 8'h00, 0, 8'h00, 1, 1, 0);
    cyc("post_rir", StRir,  0, 8'h00, 0, 8'h00, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
